// File: rtl/led_matrix_scanner.sv
// Column-multiplexed LED matrix scanner with frame-latched glyph select.
// Define LED_SCAN_BLINK_EN to build the optional frame-rate blink gate.
module led_matrix_scanner #(
  parameter int COLS         = 5,
  parameter int ROWS         = 7,
  parameter int NUM_GLYPHS   = 4,
  parameter int DIV          = 1,
  parameter int BLINK_FRAMES = 64,
  localparam int SW = (NUM_GLYPHS > 1) ? $clog2(NUM_GLYPHS) : 1,
  parameter logic [NUM_GLYPHS*COLS*ROWS-1:0] GLYPH_ROM = {
    35'd0,
    7'h06, 7'h36, 7'h3E, 7'h3E, 7'h00,
    7'h00, 7'h6E, 7'h6E, 7'h6E, 7'h00,
    7'h00, 7'h3E, 7'h3E, 7'h3E, 7'h00
  }
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            en,
  input  logic [SW-1:0]   sel,
  input  logic            blink,
  output logic [COLS-1:0] col_o,
  output logic [ROWS-1:0] row_o,
  output logic            frame_o
);

  localparam int CW = $clog2(COLS);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0]   r_presc;
  logic [CW-1:0]   r_cidx;
  logic [SW-1:0]   r_sel_q;
  logic            w_sof;
  logic            w_last;
  logic            w_dark;
  logic [SW-1:0]   w_sel;
  logic [ROWS-1:0] w_rom;

  assign w_sof  = en && (r_cidx == '0) && (r_presc == '0);
  assign w_last = (r_presc == PW'(DIV - 1));
  assign w_sel  = w_sof ? sel : r_sel_q;

  // Out-of-range selects match no entry and fall through to a dark row.
  always_comb begin
    w_rom = '0;
    for (int g = 0; g < NUM_GLYPHS; g++) begin
      for (int c = 0; c < COLS; c++) begin
        if (w_sel == SW'(g) && r_cidx == CW'(c)) begin
          w_rom = GLYPH_ROM[(g*COLS+c)*ROWS +: ROWS];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_presc <= '0;
      r_cidx  <= '0;
      r_sel_q <= '0;
    end else if (en) begin
      if (w_sof) r_sel_q <= sel;
      if (w_last) begin
        r_presc <= '0;
        r_cidx  <= (r_cidx == CW'(COLS - 1)) ? '0 : r_cidx + 1'b1;
      end else begin
        r_presc <= r_presc + 1'b1;
      end
    end
  end

`ifdef LED_SCAN_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [FW-1:0] r_fcnt;
  logic          r_phase;
  logic          r_phase_q;
  logic          r_blink_q;

  // Phase and request are frozen per frame so a frame is lit or dark whole.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_fcnt    <= '0;
      r_phase   <= 1'b0;
      r_phase_q <= 1'b0;
      r_blink_q <= 1'b0;
    end else if (w_sof) begin
      r_blink_q <= blink;
      r_phase_q <= r_phase;
      if (r_fcnt == FW'(BLINK_FRAMES - 1)) begin
        r_fcnt  <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

  assign w_dark = w_sof ? (blink & r_phase) : (r_blink_q & r_phase_q);
`else
  logic w_unused_blink;
  assign w_unused_blink = blink;
  assign w_dark = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      col_o   <= '0;
      row_o   <= '0;
      frame_o <= 1'b0;
    end else if (en) begin
      col_o   <= COLS'(1) << r_cidx;
      row_o   <= w_dark ? '0 : w_rom;
      frame_o <= w_sof;
    end else begin
      col_o   <= '0;
      row_o   <= '0;
      frame_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Bench for led_matrix_scanner: cycle model plus directed literal checks.
// Blink expectations follow LED_SCAN_BLINK_EN when the build defines it.
module tb_led_matrix_scanner;

  localparam logic [104:0] ROM3 = {
    7'h06, 7'h36, 7'h3E, 7'h3E, 7'h00,
    7'h00, 7'h6E, 7'h6E, 7'h6E, 7'h00,
    7'h00, 7'h3E, 7'h3E, 7'h3E, 7'h00
  };

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       blink = 1'b0;
  logic       en [3];
  logic [1:0] sel [3];
  logic [4:0] col [3];
  logic [6:0] row [3];
  logic       frm [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_matrix_scanner #(.DIV(1), .BLINK_FRAMES(2)) u_a (
    .CLK(clk), .RST_N(rst_n), .en(en[0]), .sel(sel[0]),
    .blink(blink), .col_o(col[0]), .row_o(row[0]), .frame_o(frm[0])
  );

  led_matrix_scanner #(.DIV(3), .BLINK_FRAMES(2)) u_b (
    .CLK(clk), .RST_N(rst_n), .en(en[1]), .sel(sel[1]),
    .blink(blink), .col_o(col[1]), .row_o(row[1]), .frame_o(frm[1])
  );

  led_matrix_scanner #(
    .NUM_GLYPHS(3), .BLINK_FRAMES(2), .GLYPH_ROM(ROM3)
  ) u_c (
    .CLK(clk), .RST_N(rst_n), .en(en[2]), .sel(sel[2]),
    .blink(blink), .col_o(col[2]), .row_o(row[2]), .frame_o(frm[2])
  );

  function automatic logic [6:0] font(int g, int c);
    case (g)
      0: return (c == 0 || c == 4) ? 7'h00 : 7'h3E;
      1: return (c == 0 || c == 4) ? 7'h00 : 7'h6E;
      2: case (c)
           0: return 7'h00;
           3: return 7'h36;
           4: return 7'h06;
           default: return 7'h3E;
         endcase
      default: return 7'h00;
    endcase
  endfunction

  // Model: pos counts enabled cycles within a frame of 5*DIV cycles.
  int         divk [3] = '{1, 3, 1};
  int         ngk  [3] = '{4, 4, 3};
  int         pos  [3] = '{0, 0, 0};
  int         nfr  [3] = '{0, 0, 0};
  int         fsel [3] = '{0, 0, 0};
  bit         fdark[3] = '{0, 0, 0};
  logic [4:0] ecol [3] = '{0, 0, 0};
  logic [6:0] erow [3] = '{0, 0, 0};
  logic       efr  [3] = '{0, 0, 0};

  initial begin
    int c;
    forever begin
      @(posedge clk or negedge rst_n);
      for (int k = 0; k < 3; k++) begin
        if (!rst_n) begin
          pos[k] = 0; nfr[k] = 0; fsel[k] = 0; fdark[k] = 0;
          ecol[k] = '0; erow[k] = '0; efr[k] = 1'b0;
        end else if (en[k]) begin
          c = pos[k] / divk[k];
          if (pos[k] == 0) begin
            fsel[k] = int'(sel[k]);
`ifdef LED_SCAN_BLINK_EN
            fdark[k] = blink && (((nfr[k] / 2) % 2) == 1);
`else
            fdark[k] = 1'b0;
`endif
            nfr[k]++;
          end
          ecol[k] = 5'(1 << c);
          erow[k] = (fsel[k] < ngk[k]) ? font(fsel[k], c) : 7'h00;
          if (fdark[k]) erow[k] = 7'h00;
          efr[k] = (pos[k] == 0);
          pos[k] = (pos[k] + 1) % (5 * divk[k]);
        end else begin
          ecol[k] = '0; erow[k] = '0; efr[k] = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if ({col[k], row[k], frm[k]} !== {ecol[k], erow[k], efr[k]}) begin
          errors++;
          $display("FAIL model dut%0d t=%0t col=%h row=%h frm=%b want col=%h row=%h frm=%b",
                   k, $time, col[k], row[k], frm[k], ecol[k], erow[k], efr[k]);
        end
      end
    end
  end

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %h want %h", nm, $time, act, exp);
    end
  endtask

  logic [4:0] colseq [5] = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10};
  logic [6:0] rowA   [5] = '{7'h00, 7'h6E, 7'h6E, 7'h6E, 7'h00};
  logic [6:0] rowG   [5] = '{7'h00, 7'h3E, 7'h3E, 7'h36, 7'h06};
  logic [4:0] swcol  [7] = '{5'h08, 5'h10, 5'h01, 5'h02, 5'h04, 5'h08, 5'h10};
  logic [6:0] swrow  [7] = '{7'h6E, 7'h00, 7'h00, 7'h3E, 7'h3E, 7'h3E, 7'h00};

  task automatic blink_window(int n);
    bit dark;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
`ifdef LED_SCAN_BLINK_EN
      dark = (i / 5) >= 2 && (i / 5) <= 3;
`else
      dark = 1'b0;
`endif
      chk("blink_col", int'(col[0]), int'(colseq[i%5]));
      chk("blink_row", int'(row[0]), dark ? 0 : int'(rowA[i%5]));
      chk("blink_frm", int'(frm[0]), int'(i % 5 == 0));
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      en[k] = 1'b0;
      sel[k] = 2'd0;
    end
    repeat (2) @(negedge clk);
    chk("rst_col", int'(col[0]), 0);
    chk("rst_row", int'(row[0]), 0);
    chk("rst_frm", int'(frm[0]), 0);

    en[0] = 1'b1; en[1] = 1'b1; en[2] = 1'b1;
    sel[0] = 2'd1; sel[1] = 2'd2; sel[2] = 2'd3;
    #2 rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("a_col", int'(col[0]), int'(colseq[i%5]));
      chk("a_row", int'(row[0]), int'(rowA[i%5]));
      chk("a_frm", int'(frm[0]), int'(i % 5 == 0));
      chk("b_col", int'(col[1]), int'(colseq[i/3]));
      chk("b_row", int'(row[1]), int'(rowG[i/3]));
      chk("b_frm", int'(frm[1]), int'(i == 0));
      chk("c_col", int'(col[2]), int'(colseq[i%5]));
      chk("c_row", int'(row[2]), 0);
    end

    repeat (3) @(negedge clk);
    chk("pre_off_col", int'(col[0]), 5'h04);
    en[0] = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("off_col", int'(col[0]), 0);
      chk("off_row", int'(row[0]), 0);
      chk("off_frm", int'(frm[0]), 0);
    end
    en[0] = 1'b1;
    @(negedge clk);
    chk("resume_col", int'(col[0]), 5'h08);
    chk("resume_row", int'(row[0]), 7'h6E);
    chk("resume_frm", int'(frm[0]), 0);
    @(negedge clk);
    chk("resume_frm2", int'(frm[0]), 0);
    @(negedge clk);
    chk("wrap_col", int'(col[0]), 5'h01);
    chk("wrap_frm", int'(frm[0]), 1);

    repeat (2) @(negedge clk);
    sel[0] = 2'd0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("sw_col", int'(col[0]), int'(swcol[i]));
      chk("sw_row", int'(row[0]), int'(swrow[i]));
    end

    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_col_a", int'(col[0]), 0);
    chk("async_col_b", int'(col[1]), 0);
    chk("async_row_b", int'(row[1]), 0);
    @(negedge clk);
    sel[0] = 2'd1;
    blink = 1'b1;
    #2 rst_n = 1'b1;

    blink_window(13);
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    blink_window(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
